logic_unit_arbiter: RTL and testbench
=====================================

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 The block SHALL use the parameter WIDTH, default 32, as the operand and result width in bits.
REQ-002 The block SHALL have the port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have the ports req0_valid / req1_valid, input, 1 bit each: requester 0/1 presents an operation.
REQ-005 The block SHALL have the ports req0_ready / req1_ready, output, 1 bit each: requester 0/1 operation accepted this cycle.
REQ-006 The block SHALL have the ports req0_a, req0_b, req1_a, req1_b, input, WIDTH bits each: operands.
REQ-007 The block SHALL have the ports req0_op / req1_op, input, 2 bits each: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-008 The block SHALL have the port resp_valid, output, 1 bit: result held on resp_data.
REQ-009 The block SHALL have the port resp_ready, input, 1 bit: consumer takes the result.
REQ-010 The block SHALL have the port resp_data, output, WIDTH bits: registered result.
REQ-011 The block SHALL have the port resp_id, output, 1 bit: index of the requester that owns resp_data.
REQ-012 The block SHALL have the port prio, output, 1 bit: requester that currently holds priority.

Function
REQ-013 The block SHALL share one bitwise logic unit between two requesters, with a single response slot.
REQ-014 The FSM SHALL have two states: IDLE (resp_valid=0) and HOLD (resp_valid=1).
REQ-015 The slot SHALL be free when state==IDLE, or when state==HOLD and resp_ready=1 in the same cycle.
REQ-016 If the slot is free and exactly one reqN_valid=1, the block SHALL grant requester N.
REQ-017 If the slot is free and both requests are valid, the block SHALL grant requester prio.
REQ-018 If the slot is not free, the block SHALL make no grant.
REQ-019 reqN_ready SHALL be combinational and equal 1 only in the cycle requester N is granted; at most one ready SHALL be high per cycle.
REQ-020 A grant SHALL be the transfer cycle: the block SHALL sample reqN_a, reqN_b and reqN_op in that cycle.
REQ-021 resp_data SHALL equal op(a,b) computed over the full WIDTH bits, with no carry and no sign handling.
REQ-022 On the edge ending a grant cycle, the block SHALL load resp_data and resp_id=N, and the state SHALL become HOLD (latency 1 cycle).
REQ-023 In HOLD with resp_ready=0, resp_data and resp_id SHALL stay stable and no grant SHALL occur.
REQ-024 In HOLD with resp_ready=1 and a grant in the same cycle, the state SHALL stay HOLD and the new result SHALL load, giving one result per cycle back-to-back.
REQ-025 In HOLD with resp_ready=1 and no grant, the state SHALL return to IDLE.
REQ-026 resp_ready in IDLE SHALL be ignored.
REQ-027 On every grant to N, prio SHALL become ~N; with no grant, prio SHALL hold.
REQ-028 A requester that drops valid before it is granted SHALL lose nothing; the block SHALL hold no pending state per requester.
REQ-029 No requester SHALL wait more than 2 grants while it holds valid=1 (fairness bound).

Reset
REQ-030 When rst_n=0 at a clk edge, the block SHALL set state=IDLE, resp_valid=0, resp_data=0, resp_id=0 and prio=0.
REQ-031 While rst_n=0, req0_ready and req1_ready SHALL be 0.
REQ-032 Reset in HOLD SHALL discard the held result without completing a handshake.
REQ-033 The first grant after reset is released SHALL follow REQ-016/017 with prio=0.

Verification
REQ-034 The bench SHALL cover: reset; req0 only with a=0xFFFF0000, b=0x0F0F0F0F, op=00 -> req0_ready=1 for 1 cycle, next cycle resp_valid=1, resp_data=0x0F0F0000, resp_id=0, prio=1.
REQ-035 The bench SHALL cover: both valid, resp_ready=1 held, req0 op=01 a=0x1 b=0x2, req1 op=10 a=0xF b=0x5 -> order req0 then req1, resp_data 0x00000003 then 0x0000000A, back-to-back with no bubble.
REQ-036 The bench SHALL cover: HOLD with resp_ready=0 for 5 cycles while both requests are valid -> resp_data stable, both readys 0, prio unchanged.
REQ-037 The bench SHALL cover: op=11 with a=0, b=0 -> resp_data=0xFFFFFFFF.
REQ-038 The bench SHALL cover: rst_n=0 for 1 cycle while in HOLD -> next cycle resp_valid=0, resp_data=0, prio=0.
REQ-039 The bench SHALL cover: both requests valid continuously for 8 grants -> resp_id alternates 0,1,0,1,...

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - two-requester arbiter sharing one bitwise logic unit
// Single response slot; alternating priority after every grant.
module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req0_op,
  input  logic [1:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id,
  output logic             prio
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             slot_free;
  logic             grant0;
  logic             grant1;
  logic             grant_any;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] result;

  always_comb begin
    slot_free  = (state == IDLE) || resp_ready;
    grant0     = 1'b0;
    grant1     = 1'b0;
    // Gating on rst_n keeps both readys low throughout reset.
    if (rst_n && slot_free) begin
      if (req0_valid && (!req1_valid || !prio)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
    grant_any  = grant0 | grant1;

    op_a   = grant1 ? req1_a  : req0_a;
    op_b   = grant1 ? req1_b  : req0_b;
    op_sel = grant1 ? req1_op : req0_op;
    case (op_sel)
      2'b00:   result = op_a & op_b;
      2'b01:   result = op_a | op_b;
      2'b10:   result = op_a ^ op_b;
      default: result = ~(op_a | op_b);
    endcase

    state_next = state;
    if (grant_any) begin
      state_next = HOLD;
    end else if ((state == HOLD) && resp_ready) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      resp_data <= '0;
      resp_id   <= 1'b0;
      prio      <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_any) begin
        resp_data <= result;
        resp_id   <= grant1;
        prio      <= ~grant1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign resp_valid = (state == HOLD);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - self-checking bench for logic_unit_arbiter
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_id;
  logic        prio;

  int checks = 0;
  int failures = 0;

  // Reference state: what the consumer should currently see.
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_id;
  logic        m_prio;
  int          wait0, wait1;

  logic_unit_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .prio(prio)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Expected grant as a one-hot {grant1, grant0}.
  function automatic logic [1:0] exp_grant();
    if (!rst_n) return 2'b00;
    if (m_valid && !resp_ready) return 2'b00;
    if (req0_valid && req1_valid) return m_prio ? 2'b10 : 2'b01;
    if (req0_valid) return 2'b01;
    if (req1_valid) return 2'b10;
    return 2'b00;
  endfunction

  task automatic set_req(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [1:0] o0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] o1,
                         input logic rr);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
    resp_ready = rr;
    #1;
  endtask

  task automatic tick();
    logic [1:0] g;
    g = exp_grant();
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_id = 1'b0; m_prio = 1'b0;
      wait0 = 0; wait1 = 0;
    end else begin
      if (g[0]) begin
        m_data = ref_op(req0_op, req0_a, req0_b); m_id = 1'b0; m_valid = 1'b1; m_prio = 1'b1;
      end else if (g[1]) begin
        m_data = ref_op(req1_op, req1_a, req1_b); m_id = 1'b1; m_valid = 1'b1; m_prio = 1'b0;
      end else if (resp_ready) begin
        m_valid = 1'b0;
      end
      wait0 = (!req0_valid || g[0]) ? 0 : wait0 + (g[1] ? 1 : 0);
      wait1 = (!req1_valid || g[1]) ? 0 : wait1 + (g[0] ? 1 : 0);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_req(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(1'b1, 32'h1, 32'h2, 2'd0, 1'b1, 32'h3, 32'h4, 2'd1, 1'b1);
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready: got %b%b want 00", req1_ready, req0_ready);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_id !== 1'b0 || prio !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got v=%b d=%h id=%b p=%b want 0 0 0 0", resp_valid, resp_data, resp_id, prio);
    end
    rst_n = 1'b1;
    set_req(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    tick();
  endtask

  task automatic test_single();
    set_req(1'b1, 32'hFFFF0000, 32'h0F0F0F0F, 2'd0, 1'b0, 0, 0, 0, 1'b0);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL single_ready: got %b%b want 01", req1_ready, req0_ready);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h0F0F0000 || resp_id !== 1'b0 || prio !== 1'b1) begin
      failures++;
      $display("FAIL single_resp: got v=%b d=%h id=%b p=%b want 1 0f0f0000 0 1", resp_valid, resp_data, resp_id, prio);
    end
    set_req(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b1);
    checks++;
    if (req0_ready !== 1'b0) begin
      failures++; $display("FAIL single_one_cycle: got ready0=%b want 0", req0_ready);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++; $display("FAIL single_release: got v=%b want 0", resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(1'b1, 32'h1, 32'h2, 2'd1, 1'b1, 32'hF, 32'h5, 2'd2, 1'b1);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_first_ready: got %b%b want 01", req1_ready, req0_ready);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h3 || resp_id !== 1'b0) begin
      failures++; $display("FAIL b2b_first: got v=%b d=%h id=%b want 1 00000003 0", resp_valid, resp_data, resp_id);
    end
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_second_ready: got %b%b want 10", req1_ready, req0_ready);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'hA || resp_id !== 1'b1) begin
      failures++; $display("FAIL b2b_second: got v=%b d=%h id=%b want 1 0000000a 1", resp_valid, resp_data, resp_id);
    end
    set_req(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b1);
    tick();
  endtask

  task automatic test_hold_stall();
    logic [31:0] held;
    logic        p;
    set_req(1'b0, 0, 0, 0, 1'b1, 32'hA5A5A5A5, 32'h0FF00FF0, 2'd2, 1'b0);
    tick();
    held = resp_data;
    p = prio;
    checks++;
    if (held !== 32'hAA55AA55 || resp_id !== 1'b1) begin
      failures++; $display("FAIL stall_load: got d=%h id=%b want aa55aa55 1", held, resp_id);
    end
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, $urandom, $urandom, 2'($urandom), 1'b1, $urandom, $urandom, 2'($urandom), 1'b0);
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        failures++; $display("FAIL stall_ready[%0d]: got %b%b want 00", i, req1_ready, req0_ready);
      end
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== held || resp_id !== 1'b1 || prio !== p) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got v=%b d=%h id=%b p=%b want 1 %h 1 %b", i, resp_valid, resp_data, resp_id, prio, held, p);
      end
    end
    set_req(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b1);
    tick();
  endtask

  task automatic test_nor();
    set_req(1'b1, 32'h0, 32'h0, 2'd3, 1'b0, 0, 0, 0, 1'b1);
    tick();
    checks++;
    if (resp_data !== 32'hFFFFFFFF || resp_valid !== 1'b1) begin
      failures++; $display("FAIL nor_zero: got v=%b d=%h want 1 ffffffff", resp_valid, resp_data);
    end
    set_req(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b1);
    tick();
  endtask

  task automatic test_reset_in_hold();
    set_req(1'b1, 32'h12345678, 32'hFFFFFFFF, 2'd0, 1'b0, 0, 0, 0, 1'b0);
    tick();
    rst_n = 1'b0;
    set_req(1'b1, 32'h1, 32'h1, 2'd1, 1'b1, 32'h2, 32'h2, 2'd1, 1'b1);
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL rst_hold_ready: got %b%b want 00", req1_ready, req0_ready);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0 || resp_data !== 32'h0 || prio !== 1'b0) begin
      failures++; $display("FAIL rst_hold: got v=%b d=%h p=%b want 0 0 0", resp_valid, resp_data, prio);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL rst_first_grant: got %b%b want 01", req1_ready, req0_ready);
    end
    tick();
    set_req(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b1);
    tick();
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, $urandom, $urandom, 2'($urandom), 1'b1, $urandom, $urandom, 2'($urandom), 1'b1);
      tick();
      checks++;
      if (resp_id !== 1'(i % 2) || resp_data !== m_data || resp_valid !== 1'b1) begin
        failures++;
        $display("FAIL alternate[%0d]: got id=%b d=%h want id=%0d d=%h", i, resp_id, resp_data, i % 2, m_data);
      end
    end
    set_req(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b1);
    tick();
  endtask

  task automatic test_random();
    logic [1:0] g;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      set_req($urandom_range(0, 2) != 0, $urandom, $urandom, 2'($urandom),
              $urandom_range(0, 2) != 0, $urandom, $urandom, 2'($urandom),
              $urandom_range(0, 2) != 0);
      g = exp_grant();
      checks++;
      if ({req1_ready, req0_ready} !== g) begin
        failures++; $display("FAIL rand_ready[%0d]: got %b%b want %b", i, req1_ready, req0_ready, g);
      end
      tick();
      checks++;
      if (resp_valid !== m_valid || resp_id !== m_id || prio !== m_prio || (m_valid && resp_data !== m_data)) begin
        failures++;
        $display("FAIL rand_resp[%0d]: got v=%b d=%h id=%b p=%b want %b %h %b %b",
                 i, resp_valid, resp_data, resp_id, prio, m_valid, m_data, m_id, m_prio);
      end
      checks++;
      if (wait0 > 2 || wait1 > 2) begin
        failures++; $display("FAIL rand_fairness[%0d]: got waits %0d/%0d want <=2", i, wait0, wait1);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    m_valid = 1'b0; m_data = '0; m_id = 1'b0; m_prio = 1'b0;
    wait0 = 0; wait1 = 0;
    rst_n = 1'b0;
    set_req(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_stall();
    test_nor();
    test_reset_in_hold();
    test_alternate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
